parity_check_scheduler: RTL and testbench
=========================================

// Module: parity_check_scheduler
// PURPOSE
//  Shares one serial odd-parity checker (start / data_in / checking / parity_error) among NUM_REQ parallel-word requesters.
//  Round-robin arbitration grants one requester per transaction. The block serializes the granted word LSB-first into the
//  checker, captures the checker's parity verdict and returns it with the requester id over a valid/ready response channel.
// PARAMETERS
//  DATA_WIDTH  8  word width; must equal the attached checker's DATA_WIDTH; >=2
//  NUM_REQ     4  number of requesters; >=2; ID_W = $clog2(NUM_REQ)
// PORTS
//  clk               in   1                   clock, all logic on posedge
//  reset             in   1                   synchronous, active-high reset
//  req_valid         in   NUM_REQ             per-requester word valid
//  req_ready         out  NUM_REQ             per-requester accept (at most one bit high)
//  req_data          in   NUM_REQ*DATA_WIDTH  word i at [i*DATA_WIDTH +: DATA_WIDTH]
//  rsp_valid         out  1                   response valid
//  rsp_ready         in   1                   response accept
//  rsp_id            out  ID_W                index of the requester served
//  rsp_data          out  DATA_WIDTH          word checked (echo)
//  rsp_parity_error  out  1                   1 = odd number of ones in word
//  rsp_proto_err     out  1                   checker failed to hold checking high during shift
//  chk_start         out  1                   to checker start
//  chk_data          out  1                   to checker data_in
//  chk_checking      in   1                   from checker checking
//  chk_parity_error  in   1                   from checker parity_error
//  busy              out  1                   state != IDLE
// BEHAVIOUR
//  FSM states: IDLE, START, SHIFT, RESP.
//  - IDLE: if any req_valid, grant = first valid index at or after rr_ptr (wrapping); req_ready[grant]=1 combinationally
//    (req_ready=0 in all other states). On req_valid&req_ready: latch word, id; rr_ptr <= grant+1 mod NUM_REQ; -> START.
//  - START (1 cycle): chk_start=1, chk_data=0 (zero is mandatory: the checker folds the start-cycle data bit into parity);
//    bit_cnt <= 0; -> SHIFT.
//  - SHIFT (DATA_WIDTH cycles): chk_data = word[bit_cnt], bit_cnt++; if chk_checking==0 in any SHIFT cycle set proto flag.
//    On bit_cnt==DATA_WIDTH-1 capture chk_parity_error into rsp_parity_error; -> RESP.
//  - RESP: rsp_valid=1 with rsp_id/rsp_data/rsp_parity_error/rsp_proto_err stable; on rsp_ready -> IDLE.
//    Checker sits in DONE during the first RESP cycle, so it is idle before any new START.
//  - chk_start=0 and chk_data=0 outside START/SHIFT.
//  Latency: accept at cycle T -> chk_start at T+1 -> bits at T+2..T+1+DATA_WIDTH -> rsp_valid at T+2+DATA_WIDTH.
//  Throughput: with rsp_ready held high, next accept at T+3+DATA_WIDTH (period DATA_WIDTH+3).
//  Arbitration: rr_ptr advances only on accept; a requester dropping req_valid before grant loses nothing.
//  No new request is accepted while RESP is pending (backpressure holds the checker idle).
//  Reset: state=IDLE, rr_ptr=0, bit_cnt=0, all outputs 0 (req_ready, rsp_*, chk_*, busy).
//  Reset mid-transaction aborts it with no response; the checker (reset on the same signal) also returns to idle.
//  rsp_proto_err cleared on each accept; rsp_parity_error still reports the captured value.
// TESTING (DATA_WIDTH=8, NUM_REQ=4, real checker attached, rsp_ready=1 unless stated)
//  1. req0 word 0x01 -> rsp_valid at accept+10, rsp_id=0, rsp_parity_error=1; chk_data seq 0 (start), 1,0,0,0,0,0,0,0.
//  2. words 0x00, 0xFF, 0x03, 0x80 via req1 -> parity_error 0,0,0,1; accepts spaced exactly 11 cycles.
//  3. all four req_valid held with distinct words -> grant order 0,1,2,3,0; rsp_id matches; one req_ready high at a time.
//  4. rsp_ready low 5 cycles in RESP -> rsp_* stable, req_ready all 0, chk_start 0; accept on 6th cycle, IDLE next.
//  5. reset asserted in 4th SHIFT cycle -> next cycle all outputs 0, state IDLE; new req0 0x07 -> parity_error 1.
//  6. stub checker forces chk_checking=0 in SHIFT -> rsp_proto_err=1; following clean transaction -> rsp_proto_err=0.

Source files
------------

// File: rtl/parity_check_scheduler.sv
// Round-robin front end that time-shares one serial odd-parity checker among
// NUM_REQ word requesters and returns each verdict over a valid/ready channel.
module parity_check_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_parity_error,
  output logic                          rsp_proto_err,
  output logic                          chk_start,
  output logic                          chk_data,
  input  logic                          chk_checking,
  input  logic                          chk_parity_error,
  output logic                          busy
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, SHIFT, RESP} state_t;

  state_t                  state;
  logic [ID_W-1:0]         rr_ptr;
  logic [CNT_W-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0]   word;
  logic [ID_W-1:0]         id;
  logic                    perr;
  logic                    proto;

  logic                    found;
  logic [ID_W-1:0]         grant;
  logic [ID_W-1:0]         next_ptr;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
        found = 1'b1;
        grant = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
  end

  assign next_ptr = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) req_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      bit_cnt <= '0;
      word    <= '0;
      id      <= '0;
      perr    <= 1'b0;
      proto   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            word   <= req_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
            id     <= grant;
            rr_ptr <= next_ptr;
            proto  <= 1'b0;
            state  <= START;
          end
        end
        START: begin
          bit_cnt <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (!chk_checking) proto <= 1'b1;
          bit_cnt <= bit_cnt + CNT_W'(1);
          // The checker's verdict already includes the bit on chk_data this cycle.
          if (bit_cnt == LAST_BIT) begin
            perr  <= chk_parity_error;
            state <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The start-cycle data bit must be zero: the checker folds it into parity.
  assign chk_start        = (state == START);
  assign chk_data         = (state == SHIFT) ? word[bit_cnt] : 1'b0;
  assign rsp_valid        = (state == RESP);
  assign rsp_id           = id;
  assign rsp_data         = word;
  assign rsp_parity_error = perr;
  assign rsp_proto_err    = proto;
  assign busy             = (state != IDLE);

endmodule

// File: tb/tb_parity_check_scheduler.sv
// Directed bench for parity_check_scheduler with a behavioural serial checker
// attached; the checker's checking line can be forced low to provoke proto errors.
module tb_parity_check_scheduler;

  localparam int DW = 8;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*DW-1:0] req_data;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [DW-1:0]   rsp_data;
  logic            rsp_parity_error;
  logic            rsp_proto_err;
  logic            chk_start;
  logic            chk_data;
  logic            chk_checking;
  logic            chk_parity_error;
  logic            busy;

  logic            stub_low;
  logic            m_chk;
  logic            m_acc;
  logic [3:0]      m_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_acc = 0;

  parity_check_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_parity_error(rsp_parity_error),
    .rsp_proto_err(rsp_proto_err),
    .chk_start(chk_start), .chk_data(chk_data),
    .chk_checking(chk_checking), .chk_parity_error(chk_parity_error),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Serial odd-parity checker: folds the start-cycle bit, then DW data bits.
  always @(posedge clk) begin
    if (reset) begin
      m_chk <= 1'b0; m_acc <= 1'b0; m_cnt <= '0;
    end else if (chk_start) begin
      m_acc <= chk_data; m_chk <= 1'b1; m_cnt <= '0;
    end else if (m_chk) begin
      m_acc <= m_acc ^ chk_data;
      m_cnt <= m_cnt + 4'd1;
      if (m_cnt == 4'(DW - 1)) m_chk <= 1'b0;
    end
  end
  assign chk_parity_error = m_acc ^ (m_chk & chk_data);
  assign chk_checking     = m_chk & ~stub_low;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Runs one transaction for requester idx and leaves the bench in its RESP cycle.
  task automatic do_txn(input int idx, input logic [7:0] w, input logic exp_err,
                        input logic exp_proto, input bit drop);
    int t;
    req_data[idx*DW +: DW] = w;
    req_valid[idx] = 1'b1;
    #1;
    t = 0;
    while (req_ready == '0 && t < 40) begin tick(); t++; end
    check_eq("grant", 32'(req_ready), 32'(1) << idx);
    if (req_ready == '0) begin
      req_valid[idx] = 1'b0;
      return;
    end
    last_acc = cyc;
    tick();
    if (drop) req_valid[idx] = 1'b0;
    check_eq("start_pulse", 32'(chk_start), 1);
    check_eq("start_data", 32'(chk_data), 0);
    check_eq("ready_in_start", 32'(req_ready), 0);
    for (int b = 0; b < DW; b++) begin
      tick();
      check_eq("shift_bit", 32'(chk_data), 32'(w[b]));
      check_eq("shift_start", 32'(chk_start), 0);
    end
    tick();
    check_eq("rsp_valid", 32'(rsp_valid), 1);
    check_eq("rsp_id", 32'(rsp_id), 32'(idx));
    check_eq("rsp_data", 32'(rsp_data), 32'(w));
    check_eq("rsp_parity", 32'(rsp_parity_error), 32'(exp_err));
    check_eq("rsp_proto", 32'(rsp_proto_err), 32'(exp_proto));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    logic [7:0] words [4];
    logic       errs  [4];

    req_valid = '0; req_data = '0; rsp_ready = 1'b1; stub_low = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    do_reset();
    check_eq("rst_ready", 32'(req_ready), 0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_chk_start", 32'(chk_start), 0);
    check_eq("rst_chk_data", 32'(chk_data), 0);
    check_eq("rst_rsp_data", 32'(rsp_data), 0);

    // 1: single word, exact latency is implied by the fixed step sequence.
    do_txn(0, 8'h01, 1'b1, 1'b0, 1'b1);

    // 2: back-to-back words via req1, accepts every DW+3 cycles.
    do_txn(1, 8'h00, 1'b0, 1'b0, 1'b1);
    prev = last_acc;
    do_txn(1, 8'hFF, 1'b0, 1'b0, 1'b1);
    check_eq("spacing_1", 32'(last_acc - prev), 11);
    prev = last_acc;
    do_txn(1, 8'h03, 1'b0, 1'b0, 1'b1);
    check_eq("spacing_2", 32'(last_acc - prev), 11);
    prev = last_acc;
    do_txn(1, 8'h80, 1'b1, 1'b0, 1'b1);
    check_eq("spacing_3", 32'(last_acc - prev), 11);
    tick();

    // 3: all requesters held valid, round-robin from pointer 0.
    do_reset();
    words[0] = 8'h11; errs[0] = 1'b0;
    words[1] = 8'h13; errs[1] = 1'b1;
    words[2] = 8'h00; errs[2] = 1'b0;
    words[3] = 8'h7F; errs[3] = 1'b1;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = words[i];
    req_valid = '1;
    for (int k = 0; k < 5; k++) do_txn(k % NR, words[k % NR], errs[k % NR], 1'b0, 1'b0);
    req_valid = '0;
    tick();

    // 4: response backpressure for five cycles.
    rsp_ready = 1'b0;
    do_txn(2, 8'h55, 1'b0, 1'b0, 1'b1);
    req_data[3*DW +: DW] = 8'h33;
    req_valid[3] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq("bp_valid", 32'(rsp_valid), 1);
      check_eq("bp_data", 32'(rsp_data), 32'h55);
      check_eq("bp_id", 32'(rsp_id), 2);
      check_eq("bp_ready", 32'(req_ready), 0);
      check_eq("bp_start", 32'(chk_start), 0);
      tick();
    end
    check_eq("bp_valid_6", 32'(rsp_valid), 1);
    rsp_ready = 1'b1;
    tick();
    check_eq("bp_idle_busy", 32'(busy), 0);
    check_eq("bp_idle_ready", 32'(req_ready), 32'h8);
    req_valid = '0;
    #1;

    // 5: reset during the fourth SHIFT cycle aborts the transaction.
    req_data[0 +: DW] = 8'h5A;
    req_valid[0] = 1'b1;
    #1;
    check_eq("abort_grant", 32'(req_ready), 1);
    tick();
    req_valid[0] = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    check_eq("abort_busy", 32'(busy), 0);
    check_eq("abort_rsp_valid", 32'(rsp_valid), 0);
    check_eq("abort_chk_start", 32'(chk_start), 0);
    check_eq("abort_chk_data", 32'(chk_data), 0);
    check_eq("abort_rsp_data", 32'(rsp_data), 0);
    check_eq("abort_ready", 32'(req_ready), 0);
    reset = 1'b0;
    do_txn(0, 8'h07, 1'b1, 1'b0, 1'b1);

    // 6: checker drops checking during shift, then a clean transaction.
    stub_low = 1'b1;
    do_txn(1, 8'h0F, 1'b0, 1'b1, 1'b1);
    stub_low = 1'b0;
    do_txn(2, 8'h01, 1'b1, 1'b0, 1'b1);
    tick();
    check_eq("final_idle", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
